// File: rtl/scp_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scp_mem_pkg
//  Description : Constants and state encoding shared by the MDR byte/word
//                paths (byte-to-word read side and word-to-byte write side).
//  Revision    : 1.0 - initial release
// ============================================================================
package scp_mem_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // Transfer state; encoding is shared with the byte-to-word path.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } mdr_state_e;

endpackage : scp_mem_pkg
`default_nettype wire

// File: rtl/mdr_in_word_byte_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : mdr_in_word_byte_splitter
//  Description : Takes one 16-bit word plus a byte address from the CPU store
//                path and issues it to the byte-wide memory bus as one
//                (byte mode) or two little-endian byte writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdr_in_word_byte_splitter
  import scp_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,         // asynchronous, active-low
  input  logic [15:0]       word_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              byte_mode,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  mdr_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mode_q, mode_d;
  logic              word_ready_q, word_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [BYTE_W-1:0] mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // High byte goes to the next address, wrapping at the top of the space.
  logic [ADDR_W-1:0] addr_inc;
  assign addr_inc = addr_q + ADDR_W'(1);

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    word_ready_d = word_ready_q;
    mem_we_d     = mem_we_q;
    mem_data_d   = mem_data_q;
    mem_addr_d   = mem_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Ready comes up on the first edge after reset and stays up here.
        word_ready_d = 1'b1;
        if (word_valid && word_ready_q) begin
          word_d       = word_in;
          addr_d       = addr_in;
          mode_d       = byte_mode;
          state_d      = S_LOW;
          mem_we_d     = 1'b1;
          mem_data_d   = word_in[BYTE_W-1:0];
          mem_addr_d   = addr_in;
          word_ready_d = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_LOW: begin
        // Low byte is re-driven from the captured word while waiting for ack.
        mem_data_d = word_q[BYTE_W-1:0];
        mem_addr_d = addr_q;
        if (mem_ack) begin
          if (mode_q) begin
            state_d      = S_IDLE;
            mem_we_d     = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            word_ready_d = 1'b1;
          end else begin
            state_d    = S_HIGH;
            mem_data_d = word_q[WORD_W-1:BYTE_W];
            mem_addr_d = addr_inc;
          end
        end
      end

      S_HIGH: begin
        if (mem_ack) begin
          state_d      = S_IDLE;
          mem_we_d     = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          word_ready_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_d      = S_IDLE;
        mem_we_d     = 1'b0;
        busy_d       = 1'b0;
        word_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any word in flight at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      addr_q       <= '0;
      mode_q       <= 1'b0;
      word_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_data_q   <= '0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      mode_q       <= mode_d;
      word_ready_q <= word_ready_d;
      mem_we_q     <= mem_we_d;
      mem_data_q   <= mem_data_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_data   = mem_data_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule : mdr_in_word_byte_splitter
`default_nettype wire

// File: tb/tb_mdr_in_word_byte_splitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdr_in_word_byte_splitter
//  Description : Directed self-checking bench for the word-to-byte splitter.
//                A queue-based model predicts the byte writes and done pulses;
//                directed steps pin exact timing and values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdr_in_word_byte_splitter;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       word_in = '0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic              byte_mode = 1'b0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [7:0]        mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_ack = 1'b0;
  logic              busy;
  logic              done;

  mdr_in_word_byte_splitter #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .addr_in    (addr_in),
    .byte_mode  (byte_mode),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .mem_data   (mem_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    bit                last;
  } wr_t;

  wr_t               exp_q[$];
  bit                exp_done = 1'b0;
  logic [ADDR_W-1:0] log_a[$];
  logic [7:0]        log_d[$];
  int                done_cnt = 0;

  // Model: each accepted word expands into its list of byte writes; a write
  // retires when the bus acknowledges it, and retiring the last one of a word
  // means done must be seen in the following cycle. Reset discards everything.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      bit nd;
      wr_t w;
      nd = 1'b0;
      if (mem_we && mem_ack) begin
        log_a.push_back(mem_addr);
        log_d.push_back(mem_data);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          nd = w.last;
        end
      end
      if (word_valid && word_ready) begin
        w.a = addr_in; w.d = word_in[7:0]; w.last = byte_mode;
        exp_q.push_back(w);
        if (!byte_mode) begin
          w.a = addr_in + ADDR_W'(1); w.d = word_in[15:8]; w.last = 1'b1;
          exp_q.push_back(w);
        end
      end
      exp_done = nd;
    end
  end

  // Compare process: on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_addr", {16'h0, mem_addr}, {16'h0, exp_q[0].a});
          chk("sb_data", {24'h0, mem_data}, {24'h0, exp_q[0].d});
        end
      end
      chk("sb_done", {31'h0, done}, {31'h0, exp_done});
      chk("sb_busy_eq_we", {31'h0, busy}, {31'h0, mem_we});
      chk("sb_ready_and_we", {31'h0, word_ready & mem_we}, 32'h0);
      if (exp_done) chk("sb_ready_with_done", {31'h0, word_ready}, 32'h1);
      if (done) done_cnt++;
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [15:0] w, input logic [ADDR_W-1:0] a, input logic bm);
    word_in = w; addr_in = a; byte_mode = bm; word_valid = 1'b1;
  endtask

  task automatic chk_bus(input string name, input logic we, input logic [7:0] d,
                         input logic [ADDR_W-1:0] a);
    chk({name, "_we"},   {31'h0, mem_we}, {31'h0, we});
    chk({name, "_data"}, {24'h0, mem_data}, {24'h0, d});
    chk({name, "_addr"}, {16'h0, mem_addr}, {16'h0, a});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int d0;
    int acc_cyc[3];
    logic [15:0] b2b_w[3];
    logic [15:0] b2b_a[3];
    logic [7:0]  exp_b[6];
    logic [15:0] exp_ab[6];

    // ---- reset state
    tick(); tick();
    chk("rst_ready", {31'h0, word_ready}, 32'h0);
    chk_bus("rst_bus", 1'b0, 8'h00, 16'h0000);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b1;
    chk("rel_ready_pre", {31'h0, word_ready}, 32'h0);
    tick();
    chk("rel_ready", {31'h0, word_ready}, 32'h1);
    mem_ack = 1'b1;

    // ---- full word, zero-wait memory
    offer(16'hBEEF, 16'h0100, 1'b0);
    tick();
    word_valid = 1'b0;
    chk_bus("full_c1", 1'b1, 8'hEF, 16'h0100);
    chk("full_c1_ready", {31'h0, word_ready}, 32'h0);
    chk("full_c1_busy", {31'h0, busy}, 32'h1);
    tick();
    chk_bus("full_c2", 1'b1, 8'hBE, 16'h0101);
    tick();
    chk("full_c3_done", {31'h0, done}, 32'h1);
    chk("full_c3_ready", {31'h0, word_ready}, 32'h1);
    chk("full_c3_we", {31'h0, mem_we}, 32'h0);
    tick();
    chk("full_c4_done", {31'h0, done}, 32'h0);
    chk_bus("full_idle_hold", 1'b0, 8'hBE, 16'h0101);

    // ---- wait states, inputs changed after accept
    mem_ack = 1'b0;
    offer(16'hCAFE, 16'h0200, 1'b0);
    tick();
    word_valid = 1'b0; word_in = 16'h1234; addr_in = 16'h0999; byte_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_bus("wait_low", 1'b1, 8'hFE, 16'h0200);
      tick();
    end
    chk_bus("wait_low_end", 1'b1, 8'hFE, 16'h0200);
    mem_ack = 1'b1;
    tick();
    chk_bus("wait_high", 1'b1, 8'hCA, 16'h0201);
    tick();
    chk("wait_done", {31'h0, done}, 32'h1);
    tick();

    // ---- byte mode
    n0 = log_a.size();
    offer(16'h12AB, 16'h0040, 1'b1);
    tick();
    word_valid = 1'b0;
    chk_bus("byte_c1", 1'b1, 8'hAB, 16'h0040);
    tick();
    chk("byte_done", {31'h0, done}, 32'h1);
    chk("byte_we_off", {31'h0, mem_we}, 32'h0);
    tick();
    chk("byte_nwrites", log_a.size() - n0, 32'd1);
    chk("byte_log_addr", {16'h0, log_a[n0]}, 32'h0040);

    // ---- address wrap
    offer(16'h5566, 16'hFFFF, 1'b0);
    tick();
    word_valid = 1'b0;
    chk_bus("wrap_lo", 1'b1, 8'h66, 16'hFFFF);
    tick();
    chk_bus("wrap_hi", 1'b1, 8'h55, 16'h0000);
    tick();
    chk("wrap_done", {31'h0, done}, 32'h1);
    tick();

    // ---- back-to-back with word_valid held high
    b2b_w[0] = 16'hA1B2; b2b_a[0] = 16'h0300;
    b2b_w[1] = 16'hC3D4; b2b_a[1] = 16'h0400;
    b2b_w[2] = 16'hE5F6; b2b_a[2] = 16'h0500;
    exp_b[0] = 8'hB2; exp_ab[0] = 16'h0300; exp_b[1] = 8'hA1; exp_ab[1] = 16'h0301;
    exp_b[2] = 8'hD4; exp_ab[2] = 16'h0400; exp_b[3] = 8'hC3; exp_ab[3] = 16'h0401;
    exp_b[4] = 8'hF6; exp_ab[4] = 16'h0500; exp_b[5] = 8'hE5; exp_ab[5] = 16'h0501;
    n0 = log_a.size();
    d0 = done_cnt;
    begin
      int k;
      int cyc;
      bit r;
      k = 0; cyc = 0;
      offer(b2b_w[0], b2b_a[0], 1'b0);
      while (k < 3 && cyc < 30) begin
        r = word_ready;
        tick();
        cyc++;
        if (r) begin
          acc_cyc[k] = cyc;
          k++;
          if (k < 3) offer(b2b_w[k], b2b_a[k], 1'b0);
        end
      end
      word_valid = 1'b0;
      chk("b2b_accepts", k, 3);
      cyc = 0;
      while ((done_cnt - d0) < 3 && cyc < 30) begin
        tick();
        cyc++;
      end
      tick();
    end
    chk("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
    chk("b2b_nwrites", log_a.size() - n0, 32'd6);
    chk("b2b_ndone", done_cnt - d0, 32'd3);
    if (log_a.size() - n0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk("b2b_log_data", {24'h0, log_d[n0+i]}, {24'h0, exp_b[i]});
        chk("b2b_log_addr", {16'h0, log_a[n0+i]}, {16'h0, exp_ab[i]});
      end
    end
    chk("model_drained", exp_q.size(), 32'd0);

    // ---- reset in the middle of the high byte
    mem_ack = 1'b0;
    offer(16'h7788, 16'h0600, 1'b0);
    tick();
    word_valid = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    chk_bus("mid_high", 1'b1, 8'h77, 16'h0601);
    d0 = done_cnt;
    #1 rst = 1'b0;
    #1;
    chk_bus("mid_rst_async", 1'b0, 8'h00, 16'h0000);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_ready", {31'h0, word_ready}, 32'h0);
    mem_ack = 1'b1;
    tick();
    rst = 1'b1;
    chk("mid_rel_ready_pre", {31'h0, word_ready}, 32'h0);
    tick();
    chk("mid_rel_ready", {31'h0, word_ready}, 32'h1);
    chk_bus("mid_rel_bus", 1'b0, 8'h00, 16'h0000);
    chk("mid_rel_busy", {31'h0, busy}, 32'h0);
    chk("mid_rel_done", {31'h0, done}, 32'h0);
    tick(); tick();
    chk("mid_no_done", done_cnt - d0, 32'd0);
    chk("mid_no_retry", {31'h0, mem_we}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mdr_in_word_byte_splitter
`default_nettype wire
